// File: rtl/led_cal_pkg.sv
// Shared state encoding and default calibration constants for the LED
// calibration controller and its windowed min/max tracker.
package led_cal_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'd0;
  localparam state_t S_DC_MEAS  = 3'd1;
  localparam state_t S_DC_ADJ   = 3'd2;
  localparam state_t S_PGA_MEAS = 3'd3;
  localparam state_t S_PGA_ADJ  = 3'd4;
  localparam state_t S_NEXT_CH  = 3'd5;
  localparam state_t S_OPERATE  = 3'd6;

  localparam int DEF_DC_WIN    = 10;
  localparam int DEF_PGA_WIN   = 50;
  localparam int DEF_SLOT      = 10;
  localparam int DEF_DC_LO     = 110;
  localparam int DEF_DC_HI     = 140;
  localparam int DEF_CLIP_LO   = 5;
  localparam int DEF_CLIP_HI   = 250;
  localparam int DEF_DC_INIT   = 64;
  localparam int DEF_DRIVE_VAL = 10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/led_cal_controller_minmax_window.sv
// Windowed min/max tracker: clear loads the window length, each enabled
// sample updates min/max and counts down; done flags the final sample.
module minmax_window #(
  parameter int W     = 8,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  input  logic [CNT_W-1:0] win_len,
  input  logic [W-1:0]     sample,
  output logic [W-1:0]     win_min,
  output logic [W-1:0]     win_max,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Combinational so the FSM leaves the measure state right after the last sample.
  assign done = en && (cnt == CNT_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_min <= '1;
      win_max <= '0;
      cnt     <= '0;
    end else if (clear) begin
      win_min <= '1;
      win_max <= '0;
      cnt     <= win_len;
    end else if (en) begin
      if (sample < win_min) win_min <= sample;
      if (sample > win_max) win_max <= sample;
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_cal_controller.sv
// Per-channel DC compensation and PGA gain calibration, then round-robin
// LED operation with one ADC capture per slot.
//
// state      | meaning
// IDLE       | dark, waiting for Find_setting
// DC_MEAS    | min/max over DC window for current channel
// DC_ADJ     | step DC_Comp toward band, or store it
// PGA_MEAS   | min/max over PGA window at current gain
// PGA_ADJ    | raise gain, or store last unclipped gain
// NEXT_CH    | advance channel or enter OPERATE
// OPERATE    | round-robin slots with stored codes
module led_cal_controller
  import led_cal_pkg::*;
#(
  parameter int N_CH      = 2,
  parameter int ADC_W     = 8,
  parameter int DC_W      = 7,
  parameter int PGA_W     = 4,
  parameter int DC_WIN    = DEF_DC_WIN,
  parameter int PGA_WIN   = DEF_PGA_WIN,
  parameter int SLOT      = DEF_SLOT,
  parameter int DC_LO     = DEF_DC_LO,
  parameter int DC_HI     = DEF_DC_HI,
  parameter int CLIP_LO   = DEF_CLIP_LO,
  parameter int CLIP_HI   = DEF_CLIP_HI,
  parameter int DC_INIT   = DEF_DC_INIT,
  parameter int DRIVE_VAL = DEF_DRIVE_VAL
) (
  input  logic                   CLK,
  input  logic                   rst_n,
  input  logic [ADC_W-1:0]       ADC,
  input  logic                   Find_setting,
  output logic [N_CH-1:0]        LED_EN,
  output logic [3:0]             LED_DRIVE,
  output logic [DC_W-1:0]        DC_Comp,
  output logic [PGA_W-1:0]       PGA_Gain,
  output logic                   CLK_Filter,
  output logic                   Cal_done,
  output logic                   Cal_fail,
  output logic [N_CH*ADC_W-1:0]  ADC_Value,
  output logic [N_CH-1:0]        Value_valid
);

  localparam int CNT_W  = $clog2(max_int(DC_WIN, PGA_WIN) + 1);
  localparam int SLOT_W = $clog2(SLOT + 1);
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [ADC_W:0]   LO_V      = (ADC_W+1)'(DC_LO);
  localparam logic [ADC_W:0]   HI_V      = (ADC_W+1)'(DC_HI);
  localparam logic [ADC_W-1:0] CLIP_LO_V = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0] CLIP_HI_V = ADC_W'(CLIP_HI);
  localparam logic [DC_W-1:0]  INIT_V    = DC_W'(DC_INIT);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  LED0      = N_CH'(1);

  state_t            state, nxt;
  logic [CH_W-1:0]   ch, ch_nxt;
  logic              last_ch;
  logic [SLOT_W-1:0] slot_cnt;
  logic              fs_q, fs_rise;
  logic [DC_W-1:0]   dc_store  [N_CH];
  logic [PGA_W-1:0]  pga_store [N_CH];

  logic              mm_clear, mm_en, mm_done;
  logic [CNT_W-1:0]  mm_len;
  logic [ADC_W-1:0]  mm_min, mm_max;
  logic [ADC_W:0]    avg;
  logic              dc_lo, dc_hi, dc_sat, clipped, gain_max;

  minmax_window #(.W(ADC_W), .CNT_W(CNT_W)) u_window (
    .clk     (CLK),
    .rst_n   (rst_n),
    .clear   (mm_clear),
    .en      (mm_en),
    .win_len (mm_len),
    .sample  (ADC),
    .win_min (mm_min),
    .win_max (mm_max),
    .done    (mm_done)
  );

  assign LED_DRIVE = 4'(DRIVE_VAL);
  assign Cal_done  = (state == S_OPERATE);

  always_comb begin
    avg      = ({1'b0, mm_max} + {1'b0, mm_min}) >> 1;
    dc_lo    = avg < LO_V;
    dc_hi    = avg > HI_V;
    dc_sat   = (dc_lo && DC_Comp == '0) || (dc_hi && DC_Comp == '1);
    clipped  = (mm_min <= CLIP_LO_V) || (mm_max >= CLIP_HI_V);
    gain_max = (PGA_Gain == '1);
    fs_rise  = Find_setting && !fs_q;
    last_ch  = (ch == LAST_CH);
    ch_nxt   = last_ch ? '0 : ch + CH_W'(1);
    mm_en    = Find_setting && (state == S_DC_MEAS || state == S_PGA_MEAS);

    nxt = state;
    case (state)
      S_IDLE:     if (Find_setting) nxt = S_DC_MEAS;
      S_DC_MEAS:  if (mm_done) nxt = S_DC_ADJ;
      S_DC_ADJ:   if (Find_setting) nxt = ((dc_lo || dc_hi) && !dc_sat) ? S_DC_MEAS : S_PGA_MEAS;
      S_PGA_MEAS: if (mm_done) nxt = S_PGA_ADJ;
      S_PGA_ADJ:  if (Find_setting) nxt = (!clipped && !gain_max) ? S_PGA_MEAS : S_NEXT_CH;
      S_NEXT_CH:  if (Find_setting) nxt = last_ch ? S_OPERATE : S_DC_MEAS;
      S_OPERATE:  if (fs_rise) nxt = S_DC_MEAS;
      default:    nxt = S_IDLE;
    endcase

    // A fresh window starts only on entry; a frozen ADJ state keeps its min/max.
    mm_clear = (nxt == S_DC_MEAS || nxt == S_PGA_MEAS) &&
               !(state == S_DC_MEAS || state == S_PGA_MEAS);
    mm_len   = (nxt == S_PGA_MEAS) ? CNT_W'(PGA_WIN) : CNT_W'(DC_WIN);
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ch          <= '0;
      slot_cnt    <= '0;
      fs_q        <= 1'b0;
      LED_EN      <= '0;
      DC_Comp     <= INIT_V;
      PGA_Gain    <= '0;
      CLK_Filter  <= 1'b0;
      Cal_fail    <= 1'b0;
      ADC_Value   <= '0;
      Value_valid <= '0;
      for (int i = 0; i < N_CH; i++) begin
        dc_store[i]  <= '0;
        pga_store[i] <= '0;
      end
    end else begin
      CLK_Filter  <= ~CLK_Filter;
      fs_q        <= Find_setting;
      Value_valid <= '0;
      state       <= nxt;
      case (state)
        S_IDLE: if (Find_setting) begin
          ch       <= '0;
          LED_EN   <= LED0;
          DC_Comp  <= INIT_V;
          PGA_Gain <= '0;
        end
        S_DC_ADJ: if (Find_setting) begin
          if (dc_lo && !dc_sat)      DC_Comp <= DC_Comp - DC_W'(1);
          else if (dc_hi && !dc_sat) DC_Comp <= DC_Comp + DC_W'(1);
          else begin
            dc_store[ch] <= DC_Comp;
            PGA_Gain     <= '0;
            if (dc_sat) Cal_fail <= 1'b1;
          end
        end
        S_PGA_ADJ: if (Find_setting) begin
          if (clipped)       pga_store[ch] <= (PGA_Gain == '0) ? '0 : PGA_Gain - PGA_W'(1);
          else if (gain_max) pga_store[ch] <= PGA_Gain;
          else               PGA_Gain      <= PGA_Gain + PGA_W'(1);
        end
        S_NEXT_CH: if (Find_setting) begin
          ch     <= ch_nxt;
          LED_EN <= LED0 << ch_nxt;
          if (last_ch) begin
            DC_Comp  <= dc_store[0];
            PGA_Gain <= pga_store[0];
            slot_cnt <= SLOT_W'(SLOT);
          end else begin
            DC_Comp  <= INIT_V;
            PGA_Gain <= '0;
          end
        end
        S_OPERATE: begin
          if (fs_rise) begin
            ch       <= '0;
            LED_EN   <= LED0;
            DC_Comp  <= INIT_V;
            PGA_Gain <= '0;
            Cal_fail <= 1'b0;
          end else if (slot_cnt == SLOT_W'(1)) begin
            ADC_Value[int'(ch)*ADC_W +: ADC_W] <= ADC;
            Value_valid[ch] <= 1'b1;
            ch       <= ch_nxt;
            LED_EN   <= LED0 << ch_nxt;
            DC_Comp  <= dc_store[ch_nxt];
            PGA_Gain <= pga_store[ch_nxt];
            slot_cnt <= SLOT_W'(SLOT);
          end else begin
            slot_cnt <= slot_cnt - SLOT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_led_cal_controller.sv
// Bench for led_cal_controller: closed-loop ADC plant during calibration,
// capture scoreboard during OPERATE.
module tb_led_cal_controller;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        Find_setting = 1'b0;
  logic [7:0]  ADC = '0;
  logic [1:0]  LED_EN;
  logic [3:0]  LED_DRIVE;
  logic [6:0]  DC_Comp;
  logic [3:0]  PGA_Gain;
  logic        CLK_Filter, Cal_done, Cal_fail;
  logic [15:0] ADC_Value;
  logic [1:0]  Value_valid;

  led_cal_controller dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .ADC          (ADC),
    .Find_setting (Find_setting),
    .LED_EN       (LED_EN),
    .LED_DRIVE    (LED_DRIVE),
    .DC_Comp      (DC_Comp),
    .PGA_Gain     (PGA_Gain),
    .CLK_Filter   (CLK_Filter),
    .Cal_done     (Cal_done),
    .Cal_fail     (Cal_fail),
    .ADC_Value    (ADC_Value),
    .Value_valid  (Value_valid)
  );

  always #5 CLK = ~CLK;

  typedef struct {int ch; logic [7:0] v;} cap_t;
  cap_t sb[$];

  int n_tests = 0, n_fail = 0;
  int mode_ch [2];
  int exp_dc  [2];
  int exp_pga [2];
  int op_cyc = 0, wraps = 0, t1 = 0, t2 = 0, t = 0;
  bit was_done = 0, alt = 0, cf_model = 0, cf_valid = 0;
  logic [6:0] prev_dc = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plant modes: 0 const 125, 1 needs DC_Comp lowered, 2 needs it raised,
  // 3 always low, 4 swing of 32 per gain step around 125.
  function automatic logic [7:0] plant();
    int v, k, m;
    k = LED_EN[1] ? 1 : 0;
    m = mode_ch[k];
    case (m)
      1:       v = 90 + (64 - int'(DC_Comp));
      2:       v = 150 - (int'(DC_Comp) - 64);
      3:       v = 20;
      4:       v = alt ? 125 + 32 * int'(PGA_Gain) : 125 - 32 * int'(PGA_Gain);
      default: v = 125;
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  task automatic tick();
    logic r;
    cap_t c;
    int ec;
    r = rst_n;
    @(negedge CLK);
    cf_model = r ? ~cf_model : 1'b0;
    if (!r) cf_valid = 1;
    if (cf_valid) chk("clk_filter", CLK_Filter, cf_model);
    ec = 0;
    if (r && Cal_done) begin
      op_cyc = was_done ? op_cyc + 1 : 0;
      ec = (op_cyc / 10) % 2;
      if (sb.size() > 0) begin
        c = sb.pop_front();
        chk("vvalid", Value_valid, 32'(1) << c.ch);
        chk("adc_value", ADC_Value[c.ch*8 +: 8], c.v);
      end else begin
        chk("vvalid_idle", Value_valid, 0);
      end
      if (op_cyc % 10 == 0 || op_cyc % 10 == 9) begin
        chk("led_en_op", LED_EN, 32'(1) << ec);
        chk("dc_op", DC_Comp, exp_dc[ec]);
        chk("pga_op", PGA_Gain, exp_pga[ec]);
      end
    end else begin
      if (was_done) sb.delete();
      chk("vvalid_cal", Value_valid, 0);
      if (r && prev_dc == 7'd0 && DC_Comp == 7'd127) wraps++;
    end
    prev_dc  = DC_Comp;
    was_done = Cal_done;
    alt      = ~alt;
    if (Cal_done) begin
      ADC = 8'(op_cyc * 7 + 40 * ec + 1);
      if (op_cyc % 10 == 9) begin
        c.ch = ec;
        c.v  = ADC;
        sb.push_back(c);
      end
    end else begin
      ADC = plant();
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!Cal_done && n < 4000) begin
      tick();
      n++;
    end
    chk("cal_reached", Cal_done, 1);
  endtask

  task automatic run_op();
    int b;
    b = 0;
    Find_setting = 1'b0;
    while (op_cyc < 64 && b < 200) begin
      tick();
      b++;
    end
    chk("op_run", op_cyc, 64);
  endtask

  task automatic restart();
    Find_setting = 1'b1;
    tick();
    chk("restart_done", Cal_done, 0);
    chk("restart_fail", Cal_fail, 0);
    chk("restart_led", LED_EN, 1);
    chk("restart_dc", DC_Comp, 64);
    chk("restart_pga", PGA_Gain, 0);
  endtask

  initial begin
    mode_ch = '{0, 0};
    exp_dc  = '{64, 64};
    exp_pga = '{15, 15};
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_led", LED_EN, 0);
    chk("rst_dc", DC_Comp, 64);
    chk("rst_pga", PGA_Gain, 0);
    chk("rst_drive", LED_DRIVE, 10);
    chk("rst_cf", CLK_Filter, 0);
    chk("rst_done", Cal_done, 0);
    chk("rst_fail", Cal_fail, 0);
    chk("rst_adcv", ADC_Value, 0);
    chk("rst_vv", Value_valid, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("idle_dark", LED_EN, 0);

    // Both channels already in band; gain climbs to the top code.
    Find_setting = 1'b1;
    wait_done(t1);
    chk("cal_time", t1, 1657);
    chk("fail_s1", Cal_fail, 0);
    run_op();

    mode_ch = '{1, 2};
    exp_dc  = '{44, 74};
    exp_pga = '{15, 15};
    restart();
    wait_done(t);
    chk("fail_s2", Cal_fail, 0);
    run_op();

    mode_ch = '{3, 4};
    exp_dc  = '{0, 64};
    exp_pga = '{15, 3};
    wraps   = 0;
    restart();
    wait_done(t);
    chk("fail_s3", Cal_fail, 1);
    chk("no_wrap", wraps, 0);
    run_op();

    // Reset in the middle of the second PGA window of channel 0.
    mode_ch = '{0, 0};
    restart();
    repeat (99) tick();
    chk("pga_mid", PGA_Gain, 1);
    chk("led_mid", LED_EN, 1);
    rst_n = 1'b0;
    tick();
    chk("rst2_led", LED_EN, 0);
    chk("rst2_dc", DC_Comp, 64);
    chk("rst2_pga", PGA_Gain, 0);
    chk("rst2_done", Cal_done, 0);
    chk("rst2_adcv", ADC_Value, 0);
    chk("rst2_vv", Value_valid, 0);
    rst_n = 1'b1;
    Find_setting = 1'b0;
    repeat (2) tick();

    // Same calibration as the first run, frozen for 7 cycles inside DC_MEAS.
    exp_dc  = '{64, 64};
    exp_pga = '{15, 15};
    Find_setting = 1'b1;
    t2 = 0;
    repeat (3) begin tick(); t2++; end
    Find_setting = 1'b0;
    repeat (7) begin
      tick();
      t2++;
      chk("frz_led", LED_EN, 1);
      chk("frz_dc", DC_Comp, 64);
      chk("frz_pga", PGA_Gain, 0);
      chk("frz_done", Cal_done, 0);
    end
    Find_setting = 1'b1;
    wait_done(t);
    t2 += t;
    chk("freeze_delay", t2 - t1, 7);
    run_op();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/led_cal_controller.md
LED_CAL_CONTROLLER -- requirements
Module: led_cal_controller

Interface
REQ-001 Parameter N_CH, default 2, number of LED channels (1..8).
REQ-002 Parameter ADC_W, default 8, ADC sample width.
REQ-003 Parameter DC_W, default 7; PGA_W, default 4; compensation and gain code widths.
REQ-004 Parameter DC_WIN, default 10, samples per DC window; PGA_WIN, default 50, samples per PGA window; SLOT, default 10, cycles per LED slot in operation.
REQ-005 Parameters DC_LO/DC_HI, defaults 110/140, DC target band; CLIP_LO/CLIP_HI, defaults 5/250, clipping limits; DC_INIT, default 64; DRIVE_VAL, default 10.
REQ-006 CLK  in  1  single clock, all logic on rising edge.
REQ-007 rst_n  in  1  reset; synchronous, active-low.
REQ-008 ADC  in  ADC_W  current sample, one per cycle.
REQ-009 Find_setting  in  1  calibration request/enable.
REQ-010 LED_EN  out  N_CH  one-hot LED select, all-zero when dark.
REQ-011 LED_DRIVE  out  4  LED current code.
REQ-012 DC_Comp  out  DC_W  active DC compensation code.
REQ-013 PGA_Gain  out  PGA_W  active PGA gain code.
REQ-014 CLK_Filter  out  1  divide-by-2 of CLK.
REQ-015 Cal_done  out  1  high while in OPERATE.
REQ-016 Cal_fail  out  1  sticky: some channel hit a DC limit.
REQ-017 ADC_Value  out  N_CH*ADC_W  per-channel captured sample, channel k at bits [k*ADC_W +: ADC_W].
REQ-018 Value_valid  out  N_CH  one-cycle pulse when channel k's ADC_Value updates.

Function
REQ-019 States: IDLE, DC_MEAS, DC_ADJ, PGA_MEAS, PGA_ADJ, NEXT_CH, OPERATE.
REQ-020 IDLE -> DC_MEAS when Find_setting=1; channel index ch=0, DC_Comp=DC_INIT, PGA_Gain=0, LED_EN=1<<ch.
REQ-021 DC_MEAS: track min/max of ADC for DC_WIN consecutive cycles, then DC_ADJ.
REQ-022 DC_ADJ (1 cycle): avg=(max+min)>>1 computed at ADC_W+1 bits; avg<DC_LO -> DC_Comp-1; avg>DC_HI -> DC_Comp+1; both -> DC_MEAS with min/max cleared (min=all-ones, max=0); in band -> store DC_Comp for ch, PGA_Gain=0, PGA_MEAS.
REQ-023 DC limit: decrement requested at 0 or increment at all-ones -> no wrap, store saturated code, set Cal_fail, go to PGA_MEAS.
REQ-024 PGA_MEAS: track min/max for PGA_WIN cycles, then PGA_ADJ.
REQ-025 PGA_ADJ: clipped (min<=CLIP_LO or max>=CLIP_HI) -> store max(gain-1,0); unclipped and gain=max code -> store gain; else gain+1, clear min/max, PGA_MEAS.
REQ-026 After PGA store -> NEXT_CH: ch<N_CH-1 -> ch+1, DC_MEAS with DC_Comp=DC_INIT; ch=N_CH-1 -> OPERATE, ch=0.
REQ-027 OPERATE: round-robin, each channel lit SLOT cycles; DC_Comp/PGA_Gain show that channel's stored codes for the whole slot.
REQ-028 OPERATE capture: on last cycle of slot, ADC_Value[ch]<=ADC, Value_valid[ch] pulses next cycle aligned with the register update; no other pulse.
REQ-029 Find_setting=0 during calibration states freezes state, counters, min/max and outputs; resumes on return to 1.
REQ-030 Find_setting rising edge in OPERATE restarts calibration at IDLE->DC_MEAS; Cal_done drops the same cycle, Cal_fail clears.
REQ-031 Find_setting level in OPERATE otherwise ignored; OPERATE runs without it.
REQ-032 CLK_Filter toggles every cycle unconditionally except during reset.
REQ-033 LED_DRIVE=DRIVE_VAL constant.

Reset
REQ-034 rst_n=0 at a rising edge: state IDLE, LED_EN=0, DC_Comp=DC_INIT, PGA_Gain=0, LED_DRIVE=DRIVE_VAL, CLK_Filter=0, Cal_done=0, Cal_fail=0, ADC_Value=0, Value_valid=0, stored codes=0; applies mid-calibration or mid-slot identically.

Structure
REQ-035 Package led_cal_pkg holds state enum and default threshold/window constants.
REQ-036 One sub-module minmax_window: clear, sample enable, window-length count, min/max outputs, done pulse; instantiated once, reused for DC and PGA windows.

Verification
REQ-037 N_CH=2, ADC constant 125 -> each channel DC stored 64 after 1 window; PGA climbs to 15 stored; Cal_done after 2*(11+16*51)+ cycles.
REQ-038 ADC model avg=100+DC_Comp-54 -> DC_Comp steps 64->... until avg>=110, stored 64; model with avg 90 at DC_INIT -> decrements, stores first in-band code.
REQ-039 ADC amplitude exceeding 250 at gain 4 -> stored PGA=3.
REQ-040 ADC forcing decrement forever -> DC_Comp reaches 0, no wrap to 127, Cal_fail=1, calibration continues.
REQ-041 OPERATE, ADC=ch-dependent value -> LED_EN alternates every 10 cycles, ADC_Value[k] updated and Value_valid[k] pulses once per slot.
REQ-042 rst_n low mid-PGA_MEAS and Find_setting dropped mid-DC_MEAS -> reset values next edge; freeze holds counters exactly.
